instr_control_unit: RTL

- Hardwired control sequencer for the single-bus CPU datapath.
- Replaces hand-driven testbench strobes with an FSM that issues the fetch phases T0–T2 and the execute phases T3–T5 (T6 optional) for register-format ALU instructions, NOP and HALT.
- Sits beside the Datapath. Drives its bus-out/bus-in strobes, ALU op select and one-hot register selects.
- Waits on a memory-ready handshake during instruction fetch.

---
 rtl/cpu_ctrl_pkg.sv | 99 +++++++++
 rtl/reg_select_decoder.sv | 29 ++
 rtl/instr_control_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  cpu_ctrl_pkg
//  Opcodes, ALU_op codes, FSM state encoding and IR field positions shared
//  by the control unit. The MUL_DIV_EN macro enables the mul/div opcodes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int IR_OPC_MSB = 31;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;
    localparam int REG_IDX_W  = 4;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHL  = 5'b01000;
    localparam logic [4:0] OPC_ROR  = 5'b01001;
    localparam logic [4:0] OPC_ROL  = 5'b01010;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_NEG = 4'b1000;
    localparam logic [3:0] ALU_NOT = 4'b1001;
    localparam logic [3:0] ALU_MUL = 4'b1010;
    localparam logic [3:0] ALU_DIV = 4'b1011;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_BINARY = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_MULDIV = 3'd3,
        CLS_HALT   = 3'd4
    } instr_class_t;

    // Undefined opcodes fall into CLS_NOP so they never write a register.
    function automatic instr_class_t classify(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: classify = CLS_BINARY;
            OPC_NEG, OPC_NOT:                   classify = CLS_UNARY;
`ifdef MUL_DIV_EN
            OPC_MUL, OPC_DIV:                   classify = CLS_MULDIV;
`endif
            OPC_HALT:                           classify = CLS_HALT;
            default:                            classify = CLS_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_op_of(input logic [4:0] opc);
        case (opc)
            OPC_ADD: alu_op_of = ALU_ADD;
            OPC_SUB: alu_op_of = ALU_SUB;
            OPC_AND: alu_op_of = ALU_AND;
            OPC_OR:  alu_op_of = ALU_OR;
            OPC_SHR: alu_op_of = ALU_SHR;
            OPC_SHL: alu_op_of = ALU_SHL;
            OPC_ROR: alu_op_of = ALU_ROR;
            OPC_ROL: alu_op_of = ALU_ROL;
            OPC_NEG: alu_op_of = ALU_NEG;
            OPC_NOT: alu_op_of = ALU_NOT;
            OPC_MUL: alu_op_of = ALU_MUL;
            OPC_DIV: alu_op_of = ALU_DIV;
            default: alu_op_of = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_select_decoder.sv
// ============================================================================
//  reg_select_decoder
//  4-bit register index plus enable to a zero-or-one-hot select vector.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_select_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_COUNT = 16
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (en && (idx == i[REG_IDX_W-1:0])) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_control_unit.sv
// ============================================================================
//  instr_control_unit
//  Hardwired fetch/execute sequencer for the single-bus datapath.
//  Optional macro MUL_DIV_EN adds mul/div sequencing through T6.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instr_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int OPC_W     = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stop,
    input  logic                 MemReady,
    input  logic [31:0]          IR,
    output logic                 Run,
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 MDRout,
    output logic                 MARin,
    output logic                 Zin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 LOin,
    output logic                 HIin,
    output logic                 IncPC,
    output logic                 Read,
    output logic [3:0]           ALU_op,
    output logic [REG_COUNT-1:0] RegIn,
    output logic [REG_COUNT-1:0] RegOut,
    output logic [3:0]           Present_state
);

    state_t                 state;
    state_t                 next_state;
    instr_class_t           cls;
    logic [OPC_W-1:0]       opcode;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;
    logic [REG_IDX_W-1:0]   out_idx;
    logic [REG_IDX_W-1:0]   in_idx;
    logic                   out_en;
    logic                   in_en;
    logic                   unused_ir;

    assign opcode    = IR[IR_OPC_MSB -: OPC_W];
    assign ra        = IR[IR_RA_LSB +: REG_IDX_W];
    assign rb        = IR[IR_RB_LSB +: REG_IDX_W];
    assign rc        = IR[IR_RC_LSB +: REG_IDX_W];
    assign cls       = classify(opcode);
    assign unused_ir = ^IR[IR_RC_LSB-1:0];

    assign Present_state = state;
    assign Run           = (state != ST_RST) && (state != ST_HALT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        ALU_op     = 4'b0000;
        out_en     = 1'b0;
        out_idx    = rb;
        in_en      = 1'b0;
        in_idx     = ra;

        case (state)
            ST_RST: next_state = ST_T0;
            ST_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC is only written back on the ready cycle so a stalled
                // fetch cannot advance it more than once.
                if (MemReady) begin
                    Zlowout    = 1'b1;
                    PCin       = 1'b1;
                    next_state = ST_T2;
                end
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (cls)
                    CLS_HALT: next_state = ST_HALT;
                    CLS_NOP:  next_state = Stop ? ST_HALT : ST_T0;
                    default:  next_state = ST_T3;
                endcase
            end
            ST_T3: begin
                out_en = 1'b1;
                if (cls == CLS_UNARY) begin
                    ALU_op     = alu_op_of(opcode);
                    Zin        = 1'b1;
                    next_state = ST_T5;
                end else begin
                    Yin        = 1'b1;
                    next_state = ST_T4;
`ifdef MUL_DIV_EN
                    if (cls == CLS_MULDIV) begin
                        out_idx = ra;
                    end
`endif
                end
            end
            ST_T4: begin
                out_en     = 1'b1;
                out_idx    = (cls == CLS_MULDIV) ? rb : rc;
                ALU_op     = alu_op_of(opcode);
                Zin        = 1'b1;
                next_state = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef MUL_DIV_EN
                if (cls == CLS_MULDIV) begin
                    LOin       = 1'b1;
                    next_state = ST_T6;
                end else begin
                    in_en      = 1'b1;
                    next_state = Stop ? ST_HALT : ST_T0;
                end
`else
                in_en      = 1'b1;
                next_state = Stop ? ST_HALT : ST_T0;
`endif
            end
`ifdef MUL_DIV_EN
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                next_state = Stop ? ST_HALT : ST_T0;
            end
`endif
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase
    end

    reg_select_decoder #(.REG_COUNT(REG_COUNT)) u_regout_dec (
        .idx    (out_idx),
        .en     (out_en),
        .onehot (RegOut)
    );

    reg_select_decoder #(.REG_COUNT(REG_COUNT)) u_regin_dec (
        .idx    (in_idx),
        .en     (in_en),
        .onehot (RegIn)
    );

endmodule

`default_nettype wire
